// File: rtl/flash_pkg.sv
// Shared types and constants for the Gigatron flash instruction fetch engine.
package flash_pkg;

  // Fetch engine states, exported on the debug port of flash_insn_fetch.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  localparam int FLASH_ADDR_W        = 22;
  localparam int ROM_ADDR_W          = 16;
  // Upper flash address bits that select the 128 KiB ROM window.
  localparam int BASE_W              = FLASH_ADDR_W - ROM_ADDR_W - 1;
  // CLOCK_50 cycles per byte access: tACC / 20 ns, rounded up.
  localparam int DEFAULT_WAIT_CYCLES = 4;
  // Wide enough for the full 1..15 wait range.
  localparam int CNT_W               = 4;

endpackage

// File: rtl/flash_word_cache.sv
// Single-entry last-word cache: remembers the most recent instruction word
// fetched from flash, keyed by its 16-bit ROM word address.
module flash_word_cache
  import flash_pkg::*;
(
  input  logic                  clk,
  input  logic                  clear,
  input  logic [ROM_ADDR_W-1:0] lookup_addr,
  output logic                  hit,
  output logic [15:0]           hit_data,
  input  logic                  fill_en,
  input  logic [ROM_ADDR_W-1:0] fill_addr,
  input  logic [15:0]           fill_data
);

  logic                  valid_q, valid_d;
  logic [ROM_ADDR_W-1:0] tag_q, tag_d;
  logic [15:0]           data_q, data_d;

  assign hit      = valid_q && (tag_q == lookup_addr);
  assign hit_data = data_q;

  // A completed flash fetch replaces the single entry.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = fill_addr;
      data_d  = fill_data;
    end
  end

  // Entry registers; clear invalidates so no word survives a reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/flash_insn_fetch.sv
// Self-timed fetch of one 16-bit Gigatron instruction from the 8-bit parallel
// flash: low byte at the even byte address, then high byte at the odd one.
// Each byte is held on FL_ADDR for WAIT_CYCLES edges before FL_DQ is captured.
// Optional macro FETCH_CACHE_EN adds a single-entry last-word cache that lets a
// repeated request for the same word complete without touching the flash.
//
// Handshake (level): the sequencer raises req and holds it (romaddr sampled
// only on the accepting edge) until insn_rdy; insn is valid while insn_rdy is
// high; the sequencer then drops req, and the following edge clears insn_rdy.
// req must be low for at least one edge between fetches.
module flash_insn_fetch
  import flash_pkg::*;
#(
  parameter int unsigned         WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter logic [BASE_W-1:0]   FLASH_BASE  = 5'h00
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    req,
  input  logic [ROM_ADDR_W-1:0]   romaddr,
  output logic [15:0]             insn,
  output logic                    insn_rdy,
  output logic                    busy,
  output logic [FLASH_ADDR_W-1:0] FL_ADDR,
  input  logic [7:0]              FL_DQ,
  output fetch_state_e            dbg_state
);

  // Counter reload: capture happens on the edge where the count reaches zero.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  fetch_state_e            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [15:0]             insn_q, insn_d;
  logic                    rdy_q, rdy_d;
  logic                    busy_q, busy_d;
  logic [FLASH_ADDR_W-1:0] fl_addr_q, fl_addr_d;

  logic                    cache_hit;
  logic [15:0]             cache_data;

`ifdef FETCH_CACHE_EN
  logic        fill_en;
  logic [15:0] fill_data;

  // The word is complete on the edge that captures the high byte.
  assign fill_en   = (state_q == RD_HI) && (cnt_q == '0);
  assign fill_data = {FL_DQ, insn_q[7:0]};

  flash_word_cache u_cache (
    .clk         (CLOCK_50),
    .clear       (reset),
    .lookup_addr (romaddr),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .fill_en     (fill_en),
    .fill_addr   (fl_addr_q[ROM_ADDR_W:1]),
    .fill_data   (fill_data)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // Next-state and next-output logic for the fetch sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    insn_d    = insn_q;
    rdy_d     = rdy_q;
    busy_d    = busy_q;
    fl_addr_d = fl_addr_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (cache_hit) begin
            insn_d  = cache_data;
            rdy_d   = 1'b1;
            state_d = DONE;
          end else begin
            fl_addr_d = {FLASH_BASE, romaddr, 1'b0};
            cnt_d     = WAIT_LOAD;
            busy_d    = 1'b1;
            state_d   = RD_LO;
          end
        end
      end
      RD_LO: begin
        if (cnt_q == '0) begin
          insn_d[7:0]  = FL_DQ;
          fl_addr_d[0] = 1'b1;
          cnt_d        = WAIT_LOAD;
          state_d      = RD_HI;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_HI: begin
        if (cnt_q == '0) begin
          insn_d[15:8] = FL_DQ;
          rdy_d        = 1'b1;
          busy_d       = 1'b0;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        // Holding req keeps the word presented; no new fetch until req drops.
        if (!req) begin
          rdy_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      insn_q    <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      fl_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      insn_q    <= insn_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      fl_addr_q <= fl_addr_d;
    end
  end

  assign insn      = insn_q;
  assign insn_rdy  = rdy_q;
  assign busy      = busy_q;
  assign FL_ADDR   = fl_addr_q;
  assign dbg_state = state_q;

endmodule
